// File: rtl/sp_ram_pm_if.sv
// sp_ram_pm_if: access and power-control bundle for sp_ram_pm.
//   master drives: AD (word address), DI (write data), MASKWE (per-lane write enable),
//                  WE (1=write), CS (access request), STDBY, SLEEP (power requests)
//   slave drives:  DO (read data), DV (read-data-valid), RDY (access accepted),
//                  DROP (refused-access pulse), PMODE (0=ACTIVE,1=STDBY,2=SLEEP,3=WAKE)
interface sp_ram_pm_if #(
    parameter int unsigned DW   = 16,
    parameter int unsigned AW   = 14,
    parameter int unsigned LANE = 4
);
    localparam int unsigned ML = DW / LANE;

    logic [AW-1:0] AD;
    logic [DW-1:0] DI;
    logic [ML-1:0] MASKWE;
    logic          WE;
    logic          CS;
    logic          STDBY;
    logic          SLEEP;
    logic [DW-1:0] DO;
    logic          DV;
    logic          RDY;
    logic          DROP;
    logic [1:0]    PMODE;

    modport master (
        output AD, DI, MASKWE, WE, CS, STDBY, SLEEP,
        input  DO, DV, RDY, DROP, PMODE
    );

    modport slave (
        input  AD, DI, MASKWE, WE, CS, STDBY, SLEEP,
        output DO, DV, RDY, DROP, PMODE
    );
endinterface

// File: rtl/sp_ram_pm.sv
// sp_ram_pm: single-port synchronous RAM with lane write masking and a
// power-mode FSM (ACTIVE/STDBY/SLEEP/WAKE) with a wake-up latency counter.
//   CK    : clock, posedge
//   RST_N : asynchronous active-low reset (array contents are not cleared)
//   bus   : sp_ram_pm_if.slave (AD, DI, MASKWE, WE, CS, STDBY, SLEEP in;
//           DO, DV, RDY, DROP, PMODE out)
// Optional macro SP_RAM_PM_OREG_EN adds an output register stage (read latency 2).
module sp_ram_pm #(
    parameter int unsigned DW       = 16,
    parameter int unsigned AW       = 14,
    parameter int unsigned LANE     = 4,
    parameter int unsigned WAKE_CYC = 4
) (
    input  logic        CK,
    input  logic        RST_N,
    sp_ram_pm_if.slave  bus
);
    localparam int unsigned ML    = DW / LANE;
    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned CW    = 8;

    // Elaboration-time parameter checks
    if (LANE == 0 || (DW % LANE) != 0) begin : g_bad_lane
        $error("sp_ram_pm: DW must be a non-zero multiple of LANE");
    end
    if (WAKE_CYC < 1 || WAKE_CYC > 255) begin : g_bad_wake
        $error("sp_ram_pm: WAKE_CYC must be in 1..255");
    end

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_STDBY  = 2'd1,
        ST_SLEEP  = 2'd2,
        ST_WAKE   = 2'd3
    } pm_state_e;

    pm_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] do_q, do_d;
    logic          dv_q, dv_d;
    logic          drop_q;

    logic [DW-1:0] mem [DEPTH];

    logic accept_c;
    logic rd_c;
    logic wr_c;
    logic clr_c;

    assign accept_c = bus.CS && (state_q == ST_ACTIVE);
    assign rd_c     = accept_c && !bus.WE;
    assign wr_c     = accept_c && bus.WE;

    // Power-mode next state and wake counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_ACTIVE: begin
                if (bus.SLEEP)      state_d = ST_SLEEP;
                else if (bus.STDBY) state_d = ST_STDBY;
            end
            ST_STDBY: begin
                if (bus.SLEEP)       state_d = ST_SLEEP;
                else if (!bus.STDBY) state_d = ST_ACTIVE;
            end
            ST_SLEEP: begin
                if (!bus.SLEEP) begin
                    state_d = ST_WAKE;
                    cnt_d   = CW'(WAKE_CYC - 1);
                end
            end
            ST_WAKE: begin
                if (bus.SLEEP)           state_d = ST_SLEEP;
                else if (cnt_q == '0)    state_d = ST_ACTIVE;
                else                     cnt_d   = cnt_q - CW'(1);
            end
            default: state_d = ST_ACTIVE;
        endcase
    end

    // DO is zeroed on the SLEEP entry edge and on every edge spent in SLEEP;
    // the latter catches a read accepted on the entry edge one edge later.
    assign clr_c = (state_d == ST_SLEEP) || (state_q == ST_SLEEP);

    // Read-data stage fed from the array
    always_comb begin
        do_d = do_q;
        dv_d = rd_c;
        if (rd_c)       do_d = mem[bus.AD];
        else if (clr_c) do_d = '0;
    end

    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_ACTIVE;
            cnt_q   <= '0;
            do_q    <= '0;
            dv_q    <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            do_q    <= do_d;
            dv_q    <= dv_d;
            drop_q  <= bus.CS && (state_q != ST_ACTIVE);
        end
    end

    // Lane-masked array write; no reset so contents survive RST_N
    always_ff @(posedge CK) begin
        if (wr_c) begin
            for (int unsigned i = 0; i < ML; i++) begin
                if (bus.MASKWE[i]) mem[bus.AD][i*LANE +: LANE] <= bus.DI[i*LANE +: LANE];
            end
        end
    end

`ifdef SP_RAM_PM_OREG_EN
    logic [DW-1:0] oreg_do_q;
    logic          oreg_dv_q;

    // Second output stage; SLEEP entry flushes it and kills an in-flight DV
    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            oreg_do_q <= '0;
            oreg_dv_q <= 1'b0;
        end else begin
            oreg_do_q <= clr_c ? '0 : do_q;
            oreg_dv_q <= dv_q && !clr_c;
        end
    end

    assign bus.DO = oreg_do_q;
    assign bus.DV = oreg_dv_q;
`else
    assign bus.DO = do_q;
    assign bus.DV = dv_q;
`endif

    assign bus.RDY   = (state_q == ST_ACTIVE);
    assign bus.DROP  = drop_q;
    assign bus.PMODE = 2'(state_q);

endmodule

// File: tb/tb_sp_ram_pm.sv
// tb_sp_ram_pm: directed test of sp_ram_pm against a cycle-level behavioural model.
module tb_sp_ram_pm;
    localparam int unsigned DW       = 16;
    localparam int unsigned AW       = 14;
    localparam int unsigned LANE     = 4;
    localparam int unsigned WAKE_CYC = 4;
    localparam int unsigned ML       = DW / LANE;
    localparam int unsigned DEPTH    = 1 << AW;
`ifdef SP_RAM_PM_OREG_EN
    localparam int RD_LAT = 2;
`else
    localparam int RD_LAT = 1;
`endif
    localparam int P_ACT = 0, P_SB = 1, P_SL = 2, P_WK = 3;

    logic CK;
    logic RST_N;
    logic chk_en;
    int   n_cmp;
    int   n_bad;

    sp_ram_pm_if #(.DW(DW), .AW(AW), .LANE(LANE)) bus ();

    sp_ram_pm #(.DW(DW), .AW(AW), .LANE(LANE), .WAKE_CYC(WAKE_CYC)) dut (
        .CK    (CK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial begin
        CK = 1'b0;
        forever #5 CK = ~CK;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int            m_st;
    int            m_cyc;
    int            m_wake_t0;
    logic [DW-1:0] m_mem [DEPTH];
    logic [DW-1:0] m_rdat;
    logic          m_rval;
    logic [DW-1:0] m_do;
    logic          m_dv;
    logic          m_drop;

    always @(posedge CK or negedge RST_N) begin : model
        int            nx;
        logic          acc;
        logic          rd;
        logic          sleepy;
        logic [DW-1:0] bm;
        if (!RST_N) begin
            m_st   = P_ACT;
            m_rdat = '0;
            m_rval = 1'b0;
            m_do   = '0;
            m_dv   = 1'b0;
            m_drop = 1'b0;
        end else begin
            m_cyc++;
            acc    = bus.CS && (m_st == P_ACT);
            rd     = acc && !bus.WE;
            m_drop = bus.CS && (m_st != P_ACT);
            nx = m_st;
            if (m_st == P_ACT)      nx = bus.SLEEP ? P_SL : (bus.STDBY ? P_SB : P_ACT);
            else if (m_st == P_SB)  nx = bus.SLEEP ? P_SL : (bus.STDBY ? P_SB : P_ACT);
            else if (m_st == P_SL) begin
                if (!bus.SLEEP) begin
                    nx = P_WK;
                    m_wake_t0 = m_cyc;
                end
            end else begin
                if (bus.SLEEP) nx = P_SL;
                else if (m_cyc - m_wake_t0 >= int'(WAKE_CYC)) nx = P_ACT;
            end
            sleepy = (nx == P_SL) || (m_st == P_SL);
`ifdef SP_RAM_PM_OREG_EN
            m_do = sleepy ? '0 : m_rdat;
            m_dv = m_rval && !sleepy;
`endif
            if (rd)          m_rdat = m_mem[bus.AD];
            else if (sleepy) m_rdat = '0;
            m_rval = rd;
`ifndef SP_RAM_PM_OREG_EN
            m_do = m_rdat;
            m_dv = m_rval;
`endif
            if (acc && bus.WE) begin
                bm = '0;
                for (int i = 0; i < int'(ML); i++)
                    if (bus.MASKWE[i]) bm = bm | (DW'((1 << LANE) - 1) << (i * LANE));
                m_mem[bus.AD] = (m_mem[bus.AD] & ~bm) | (bus.DI & bm);
            end
            m_st = nx;
        end
    end

    // Every-cycle compare against the model
    always @(negedge CK) begin
        if (chk_en) begin
            chk("DO",    32'(bus.DO),    32'(m_do));
            chk("DV",    32'(bus.DV),    32'(m_dv));
            chk("RDY",   32'(bus.RDY),   32'(m_st == P_ACT));
            chk("DROP",  32'(bus.DROP),  32'(m_drop));
            chk("PMODE", 32'(bus.PMODE), 32'(m_st));
            chk("DO_known", 32'($isunknown(bus.DO)), 32'(0));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge CK);
        #1;
    endtask

    task automatic idle();
        bus.CS     = 1'b0;
        bus.WE     = 1'b0;
        bus.MASKWE = '0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [ML-1:0] m);
        bus.CS = 1'b1; bus.WE = 1'b1; bus.AD = a; bus.DI = d; bus.MASKWE = m;
        step();
        idle();
    endtask

    task automatic rd(input logic [AW-1:0] a);
        bus.CS = 1'b1; bus.WE = 1'b0; bus.AD = a;
        step();
        idle();
        repeat (RD_LAT - 1) step();
    endtask

    task automatic wait_rdy(input string nm);
        int k;
        for (k = 0; k < 40 && !bus.RDY; k++) step();
        chk(nm, 32'(bus.RDY), 32'(1));
    endtask

    int exp_pm [5];
    int exp_rdy [5];
    int nwake;

    initial begin
        chk_en = 1'b0;
        n_cmp = 0;
        n_bad = 0;
        m_cyc = 0;
        m_wake_t0 = 0;
        RST_N = 1'b0;
        bus.AD = '0; bus.DI = '0; bus.MASKWE = '0;
        bus.WE = 1'b0; bus.CS = 1'b0; bus.STDBY = 1'b0; bus.SLEEP = 1'b0;
        step();
        step();
        chk("rst_DO",    32'(bus.DO),    32'(0));
        chk("rst_DV",    32'(bus.DV),    32'(0));
        chk("rst_RDY",   32'(bus.RDY),   32'(1));
        chk("rst_DROP",  32'(bus.DROP),  32'(0));
        chk("rst_PMODE", 32'(bus.PMODE), 32'(0));
        RST_N = 1'b1;
        chk_en = 1'b1;

        // Preload of addresses read later
        wr(14'd0, 16'h5A00, 4'hF);
        wr(14'd7, 16'h0777, 4'hF);

        // Lane-masked write
        wr(14'd5, 16'hFFFF, 4'hF);
        wr(14'd5, 16'h1234, 4'b0101);
        wr(14'd5, 16'h9999, 4'b0000);
        rd(14'd5);
        chk("mask_DO", 32'(bus.DO), 32'h0000_F2F4);
        chk("mask_DV", 32'(bus.DV), 32'(1));
        step();
        chk("mask_DV_pulse", 32'(bus.DV), 32'(0));
        chk("mask_DO_hold",  32'(bus.DO), 32'h0000_F2F4);

        // Back-to-back write then read at top address, then preloaded address 0
        wr(14'h3FFF, 16'hA5A5, 4'hF);
        rd(14'h3FFF);
        chk("b2b_DO", 32'(bus.DO), 32'h0000_A5A5);
        rd(14'd0);
        chk("addr0_DO", 32'(bus.DO), 32'h0000_5A00);

        // Sleep 3 cycles then full wake
        bus.SLEEP = 1'b1;
        step();
        chk("slp_PMODE", 32'(bus.PMODE), 32'(2));
        chk("slp_DO",    32'(bus.DO),    32'(0));
        step();
        step();
        bus.SLEEP = 1'b0;
        chk("slp_PMODE_N", 32'(bus.PMODE), 32'(2));
        exp_pm  = '{3, 3, 3, 3, 0};
        exp_rdy = '{0, 0, 0, 0, 1};
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("wake_PMODE%0d", i), 32'(bus.PMODE), 32'(exp_pm[i]));
            chk($sformatf("wake_RDY%0d", i),   32'(bus.RDY),   32'(exp_rdy[i]));
            chk($sformatf("wake_DO%0d", i),    32'(bus.DO),    32'(0));
        end
        rd(14'd5);
        chk("post_wake_DO", 32'(bus.DO), 32'h0000_F2F4);

        // Refused write in STDBY
        bus.STDBY = 1'b1;
        step();
        chk("sb_PMODE", 32'(bus.PMODE), 32'(1));
        chk("sb_RDY",   32'(bus.RDY),   32'(0));
        chk("sb_DO",    32'(bus.DO),    32'h0000_F2F4);
        bus.CS = 1'b1; bus.WE = 1'b1; bus.AD = 14'd7; bus.DI = 16'h0BAD; bus.MASKWE = 4'hF;
        step();
        idle();
        chk("drop_pulse", 32'(bus.DROP), 32'(1));
        step();
        chk("drop_end", 32'(bus.DROP), 32'(0));
        bus.STDBY = 1'b0;
        step();
        chk("sb_exit_RDY", 32'(bus.RDY), 32'(1));
        rd(14'd7);
        chk("drop_keep_DO", 32'(bus.DO), 32'h0000_0777);

        // Wake aborted on its second cycle, then a full wake
        bus.SLEEP = 1'b1;
        step();
        step();
        bus.SLEEP = 1'b0;
        step();
        chk("abort_wk1", 32'(bus.PMODE), 32'(3));
        step();
        chk("abort_wk2", 32'(bus.PMODE), 32'(3));
        bus.SLEEP = 1'b1;
        step();
        chk("abort_back", 32'(bus.PMODE), 32'(2));
        chk("abort_RDY",  32'(bus.RDY),   32'(0));
        bus.SLEEP = 1'b0;
        nwake = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (bus.PMODE == 2'd3) nwake++;
            if (bus.RDY) break;
        end
        chk("abort_wake_len", 32'(nwake), 32'(WAKE_CYC));
        chk("abort_RDY_end",  32'(bus.RDY), 32'(1));

        // Read accepted on the SLEEP entry edge
        bus.CS = 1'b1; bus.WE = 1'b0; bus.AD = 14'd0; bus.SLEEP = 1'b1;
        step();
        idle();
`ifndef SP_RAM_PM_OREG_EN
        chk("sre_DV", 32'(bus.DV), 32'(1));
        chk("sre_DO", 32'(bus.DO), 32'h0000_5A00);
`endif
        step();
        chk("sre_DO_clr", 32'(bus.DO), 32'(0));
        chk("sre_DV_clr", 32'(bus.DV), 32'(0));
        bus.SLEEP = 1'b0;
        wait_rdy("sre_wake");

        // Async reset with a read in flight
        bus.CS = 1'b1; bus.WE = 1'b0; bus.AD = 14'h3FFF;
        step();
        idle();
        #1 RST_N = 1'b0;
        #1;
        chk("rrd_DV", 32'(bus.DV), 32'(0));
        chk("rrd_DO", 32'(bus.DO), 32'(0));
        #1 RST_N = 1'b1;
        step();

        // Async reset mid-WAKE
        bus.SLEEP = 1'b1;
        step();
        bus.SLEEP = 1'b0;
        step();
        step();
        chk("rwk_pre", 32'(bus.PMODE), 32'(3));
        #1 RST_N = 1'b0;
        #1;
        chk("rwk_PMODE", 32'(bus.PMODE), 32'(0));
        chk("rwk_RDY",   32'(bus.RDY),   32'(1));
        chk("rwk_DO",    32'(bus.DO),    32'(0));
        chk("rwk_DV",    32'(bus.DV),    32'(0));
        #1 RST_N = 1'b1;
        step();
        rd(14'h3FFF);
        chk("retain_3FFF", 32'(bus.DO), 32'h0000_A5A5);
        rd(14'd5);
        chk("retain_5", 32'(bus.DO), 32'h0000_F2F4);
        step();
        step();

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sp_ram_pm.md
Name: sp_ram_pm

Overview:
- Parametrised single-port synchronous RAM with lane-granular write masking and an explicit power-mode state machine (ACTIVE/STDBY/SLEEP/WAKE).
- Next-generation replacement for the fixed 16x16K SPRAM model used by the eForth core and the Verilator sim.
- Adds parametrised width, depth and mask granularity, a ready/valid handshake, a wake-up latency counter and a dropped-access indication.
- Fully deterministic: no X is ever driven on outputs.

Parameters:
- DW, 16: data width in bits; must be a multiple of LANE, otherwise elaboration error.
- AW, 14: address width; depth = 2**AW words.
- LANE, 4: bits per write-mask lane; mask width ML = DW/LANE.
- WAKE_CYC, 4: cycles spent in WAKE after SLEEP deasserts; range 1..255.

Ports:
- CK  in  1: clock, all logic on posedge.
- RST_N  in  1: asynchronous active-low reset.
- AD  in  AW: word address.
- DI  in  DW: write data.
- MASKWE  in  ML: per-lane write enable; bit i covers DI[i*LANE +: LANE].
- WE  in  1: 1 = write, 0 = read; sampled with CS.
- CS  in  1: access request.
- STDBY  in  1: standby request (level).
- SLEEP  in  1: sleep request (level); has priority over STDBY.
- DO  out  DW: read data.
- DV  out  1: read-data-valid pulse.
- RDY  out  1: array accepts an access this cycle.
- DROP  out  1: one-cycle pulse when CS=1 while RDY=0.
- PMODE  out  2: encoding 0=ACTIVE, 1=STDBY, 2=SLEEP, 3=WAKE.

Behaviour:
- Reset (RST_N low, asynchronous):
  - State=ACTIVE, wake counter=0.
  - DO=0, DV=0, DROP=0, RDY=1, PMODE=0.
  - Array contents are not cleared.
- RDY is combinational: RDY = (state==ACTIVE).
- An access is accepted when CS & RDY.
- Read, accepted at edge N:
  - DO = mem[AD] and DV=1 after edge N+1 (latency 1).
  - DV is high for one cycle only.
  - DO holds its value until the next read or a SLEEP entry.
- Write, accepted:
  - Each lane with MASKWE[i]=1 is updated; other lanes are unchanged.
  - MASKWE all-zero performs no write.
  - DO and DV are unaffected (DV=0).
- Read of an address written in the previous cycle returns the new data. Reads and writes never coincide, because the RAM is single-port.
- DROP = CS & ~RDY, registered, so it pulses one cycle after the refused request. Refused accesses have no effect on the array or on DO.
- State transitions, evaluated each edge, first match wins:
  - ACTIVE: SLEEP -> SLEEP; STDBY -> STDBY; else stay.
  - STDBY: SLEEP -> SLEEP; ~STDBY -> ACTIVE, with RDY=1 the following cycle; else stay.
  - SLEEP: ~SLEEP -> WAKE, loading counter = WAKE_CYC-1; else stay.
  - WAKE: SLEEP -> SLEEP (counter abandoned); counter==0 -> ACTIVE (STDBY is then evaluated from ACTIVE on the next edge); else counter-1.
- Data retention: contents are retained in STDBY, SLEEP and WAKE.
- DO in low-power states:
  - Entering SLEEP clears DO to 0 on the transition edge. DO stays 0 until a new read completes.
  - In STDBY, DO holds its last value.
- Read accepted on the same edge that SLEEP is asserted:
  - The read completes, DV=1 on the next cycle with valid data.
  - The SLEEP clear of DO applies at the following edge.
- Timing from SLEEP deassertion to RDY:
  - SLEEP deasserted at edge N gives RDY=1 from edge N+1+WAKE_CYC onward.
  - With WAKE_CYC=1, the block spends exactly one cycle in WAKE.
- Reset mid-WAKE or mid-read: the block returns to the reset values immediately, and any pending DV is lost.
- Address wrap: AD uses all AW bits, so there is no out-of-range case.

Optional Feature:
- Macro: SP_RAM_PM_OREG_EN.
- When defined:
  - An extra output register stage is added.
  - Read latency becomes 2 cycles; DV is delayed to match.
  - Both DO stages clear on SLEEP entry, and an in-flight DV is suppressed.
  - RDY and write behaviour are unchanged.
- When undefined: read latency is 1 cycle, as described above.

Test Plan:
- Mask write: write AD=5, DI=16'hFFFF, MASKWE=4'hF; then write DI=16'h1234, MASKWE=4'b0101; then read AD=5 -> DO=16'hF2F4, DV=1 exactly 1 cycle (2 with OREG) after the read edge.
- Back-to-back: write AD=0x3FFF, DI=16'hA5A5, then read AD=0x3FFF on the next cycle -> DO=16'hA5A5. Then read AD=0 (never written) -> DO is whatever reset/sim init value the bench preloaded, and never X.
- Sleep/wake: assert SLEEP 3 cycles, deassert at edge N with WAKE_CYC=4 -> PMODE sequence 2,3,3,3,3,0, RDY=1 from N+5, DO=0 throughout, earlier data readable afterwards.
- Drop: hold STDBY=1 and issue CS=1, WE=1, AD=7, DI=16'h0BAD -> DROP pulses 1 cycle, RDY=0. After STDBY drops, a read of AD=7 returns the old value.
- Wake abort: SLEEP deasserted, then reasserted at the 2nd WAKE cycle -> PMODE returns to 2, no RDY pulse occurs. A full wake afterwards still takes WAKE_CYC cycles.
- Async reset: assert RST_N=0 mid-WAKE with a read pending -> DO=0, DV=0, PMODE=0, RDY=1 immediately without a clock edge. Contents written before the reset still read back correctly.
